hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage CPU. Drives the enable and flush of the
//  PC, IF/ID and ID/EX registers, and the D-stage forwarding selects.

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage CPU. It makes the stall decision
//   for the instruction in D by comparing Tuse against Tnew for the E and M stage
//   destinations, drives the PC / IF/ID enables and the ID/EX flush, selects the
//   D-stage forwarding sources, and owns the mult/div busy counter that holds
//   HI/LO users in D.
//
//   Optional feature macro: HAZARD_STATS_EN adds a saturating 32-bit stall_cnt output.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   rs_d, rt_d              source register indices of the D instruction
//   tuse_rs_d, tuse_rt_d    cycles until D needs rs/rt (3 = not used)
//   a3_e, tnew_e            E-stage destination (0 = none) and cycles to result
//   a3_m, tnew_m            M-stage destination (0 = none) and cycles to result
//   md_start_e, md_is_div_e mult/div starting in E, and whether it is a div
//   md_use_d                D instruction touches the mult/div unit or HI/LO
//   pc_en, ifid_en          front-end enables (low while stalling)
//   idex_flush              bubble into ID/EX while stalling
//   md_busy                 mult/div unit busy
//   fwd_rs_d, fwd_rt_d      0 = regfile, 1 = from E, 2 = from M
//   stall_cnt               (HAZARD_STATS_EN only) saturating stall-cycle count
//
// Busy FSM
//   state | meaning
//   IDLE  | cnt == 0, unit free, a start in E loads the cycle count
//   BUSY  | cnt != 0, counting down one per cycle, HI/LO users held in D
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] a3_e,
  input  logic [1:0] tnew_e,
  input  logic [4:0] a3_m,
  input  logic [1:0] tnew_m,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  input  logic       md_use_d,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_flush,
  output logic       md_busy,
  output logic [1:0] fwd_rs_d,
`ifdef HAZARD_STATS_EN
  output logic [1:0] fwd_rt_d,
  output logic [31:0] stall_cnt
`else
  output logic [1:0] fwd_rt_d
`endif
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_load_d;

  logic stall_rs, stall_rt, stall_md, stall;

  // A source stalls only when its producer is still further from ready than
  // the consumer can tolerate; $0 is never a real dependency.
  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] ae, input logic [1:0] te,
                                     input logic [4:0] am, input logic [1:0] tm);
    return (r != 5'd0) && (((r == ae) && (tuse < te)) || ((r == am) && (tuse < tm)));
  endfunction

  // E is the younger producer, so it wins over M when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic [4:0] ae, input logic [1:0] te,
                                         input logic [4:0] am, input logic [1:0] tm);
    if ((r != 5'd0) && (r == ae) && (te == 2'd0))      return 2'd1;
    else if ((r != 5'd0) && (r == am) && (tm == 2'd0)) return 2'd2;
    else                                               return 2'd0;
  endfunction

  assign stall_rs = src_stall(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
  assign stall_rt = src_stall(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
  // Covers the start cycle too, before the counter has been loaded.
  assign stall_md = md_use_d && (md_busy || md_start_e);
  assign stall    = stall_rs || stall_rt || stall_md;

  assign pc_en      = !stall;
  assign ifid_en    = !stall;
  assign idex_flush = stall;

  assign fwd_rs_d = fwd_sel(rs_d, a3_e, tnew_e, a3_m, tnew_m);
  assign fwd_rt_d = fwd_sel(rt_d, a3_e, tnew_e, a3_m, tnew_m);

  assign cnt_load_d = md_is_div_e ? DIV_LOAD : MULT_LOAD;

  // BUSY tracks cnt != 0 exactly, so md_busy comes straight off a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start_e) begin
            cnt_q   <= cnt_load_d;
            state_q <= (cnt_load_d != 4'd0) ? BUSY : IDLE;
          end
        end
        BUSY: begin
          // Starts seen here are ignored: the D-stage stall keeps them out.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign md_busy = (state_q == BUSY);

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= 32'd0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, a3_e, a3_m;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic       md_start_e, md_is_div_e, md_use_d;
  logic       pc_en, ifid_en, idex_flush, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .a3_e(a3_e), .tnew_e(tnew_e), .a3_m(a3_m), .tnew_m(tnew_m),
    .md_start_e(md_start_e), .md_is_div_e(md_is_div_e), .md_use_d(md_use_d),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_flush(idex_flush), .md_busy(md_busy),
    .fwd_rs_d(fwd_rs_d),
`ifdef HAZARD_STATS_EN
    .fwd_rt_d(fwd_rt_d),
    .stall_cnt(stall_cnt)
`else
    .fwd_rt_d(fwd_rt_d)
`endif
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        busy;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: one expectation per cycle, compared mid-cycle away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic ok;
      e  = sb.pop_front();
      ok = (pc_en == !e.stall) && (ifid_en == !e.stall) && (idex_flush == e.stall) &&
           (md_busy == e.busy) && (fwd_rs_d == e.frs) && (fwd_rt_d == e.frt);
`ifdef HAZARD_STATS_EN
      if (e.chk_cnt && (stall_cnt != e.cnt)) ok = 1'b0;
`endif
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL %s: got pc_en=%0b ifid_en=%0b flush=%0b busy=%0b frs=%0d frt=%0d, want stall=%0b busy=%0b frs=%0d frt=%0d",
                 e.name, pc_en, ifid_en, idex_flush, md_busy, fwd_rs_d, fwd_rt_d,
                 e.stall, e.busy, e.frs, e.frt);
      end
`ifdef HAZARD_STATS_EN
      if (e.chk_cnt && (stall_cnt != e.cnt))
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic st, input logic bz,
                      input logic [1:0] frs, input logic [1:0] frt,
                      input logic chk, input logic [31:0] cnt);
    exp_t e;
    e.name = nm; e.stall = st; e.busy = bz; e.frs = frs; e.frt = frt;
    e.chk_cnt = chk; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic quiet();
    rs_d = 0; rt_d = 0; tuse_rs_d = 3; tuse_rt_d = 3;
    a3_e = 0; tnew_e = 0; a3_m = 0; tnew_m = 0;
  endtask

  task automatic set_md(input logic st, input logic dv, input logic use_, input logic rst);
    md_start_e = st; md_is_div_e = dv; md_use_d = use_; reset = rst;
  endtask

  // Directed register-hazard vectors:
  // rs, tuse_rs, rt, tuse_rt, a3_e, tnew_e, a3_m, tnew_m -> stall, frs, frt, stall_cnt
  typedef struct {
    string      name;
    logic [4:0] rs;  logic [1:0] trs;
    logic [4:0] rt;  logic [1:0] trt;
    logic [4:0] ae;  logic [1:0] te;
    logic [4:0] am;  logic [1:0] tm;
    logic       st;  logic [1:0] frs; logic [1:0] frt;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$] = '{
    '{"reset_idle",   0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0},
    '{"load_use",     5, 1, 0, 3, 5, 2, 0, 0, 1, 0, 0, 0},
    '{"alu_branch_e", 0, 3, 8, 0, 8, 0, 0, 0, 0, 0, 1, 1},
    '{"alu_branch_m", 0, 3, 8, 0, 0, 0, 8, 0, 0, 0, 2, 1},
    '{"zero_reg",     0, 0, 0, 3, 0, 2, 0, 0, 0, 0, 0, 1},
    '{"e_over_m",     3, 0, 0, 3, 3, 0, 3, 0, 0, 1, 0, 1},
    '{"m_stall_rt",   0, 3, 7, 0, 0, 0, 7, 1, 1, 0, 0, 1},
    '{"tuse_eq_tnew", 9, 1, 0, 3, 9, 1, 0, 0, 0, 0, 0, 2},
    '{"tuse_unused",  4, 3, 0, 3, 4, 2, 0, 0, 0, 0, 0, 2},
    '{"dual_stall",   5, 0, 6, 0, 5, 2, 6, 1, 1, 0, 0, 2}
  };

  initial begin
    quiet();
    set_md(0, 0, 0, 1);
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      next_cycle();
      reset = 0;
      rs_d = vecs[i].rs; tuse_rs_d = vecs[i].trs;
      rt_d = vecs[i].rt; tuse_rt_d = vecs[i].trt;
      a3_e = vecs[i].ae; tnew_e = vecs[i].te;
      a3_m = vecs[i].am; tnew_m = vecs[i].tm;
      push(vecs[i].name, vecs[i].st, 0, vecs[i].frs, vecs[i].frt, 1, vecs[i].cnt);
    end

    // Div: start with a HI/LO user already waiting in D, then 10 busy cycles.
    next_cycle(); quiet(); set_md(1, 1, 1, 0);
    push("div_start", 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      next_cycle(); set_md(0, 0, 1, 0);
      push($sformatf("div_busy%0d", k), 1, 1, 0, 0, 0, 0);
    end
    next_cycle(); set_md(0, 0, 1, 0);
    push("div_release", 0, 0, 0, 0, 0, 0);
    next_cycle(); set_md(0, 0, 0, 0);
    push("div_idle", 0, 0, 0, 0, 0, 0);

    // Mult: start without a user in D (no stall), then 5 busy cycles.
    next_cycle(); set_md(1, 0, 0, 0);
    push("mult_start", 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); set_md(0, 0, 1, 0);
      push($sformatf("mult_busy%0d", k), 1, 1, 0, 0, 0, 0);
    end
    next_cycle(); set_md(0, 0, 1, 0);
    push("mult_release", 0, 0, 0, 0, 0, 0);

    // Reset during busy cycle 3 of a div aborts the count at the next edge.
    next_cycle(); set_md(1, 1, 1, 0);
    push("rst_div_start", 1, 0, 0, 0, 0, 0);
    next_cycle(); set_md(0, 0, 1, 0);
    push("rst_div_busy1", 1, 1, 0, 0, 0, 0);
    next_cycle(); set_md(0, 0, 1, 0);
    push("rst_div_busy2", 1, 1, 0, 0, 0, 0);
    next_cycle(); set_md(0, 0, 1, 1);
    push("rst_div_busy3", 1, 1, 0, 0, 0, 0);
    next_cycle(); set_md(0, 0, 1, 0);
    push("rst_abort", 0, 0, 0, 0, 1, 0);
    next_cycle(); set_md(0, 0, 1, 0);
    push("rst_after", 0, 0, 0, 0, 1, 0);

    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      if (sb.size() > 0) begin
        n_miss++;
        $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
